// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 service loader.
//
// Contents:
//   op_t            - command opcode carried in bits [7:6] of a command byte
//   loader_state_t  - service loader FSM states
//   CMD_RSVD_MASK   - bits of a command byte that must be zero
//   len_to_count    - maps a length header byte to a transfer count (0 -> 256)
//   cmd_is_legal    - true when the reserved command bits are all zero
package cpu8_pkg;

    typedef enum logic [1:0] {
        OP_LOADP = 2'b00,
        OP_LOADD = 2'b01,
        OP_DUMPD = 2'b10,
        OP_RUN   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_WRITE   = 3'd3,
        ST_READ    = 3'd4,
        ST_START   = 3'd5,
        ST_RUNNING = 3'd6
    } loader_state_t;

    localparam logic [7:0] CMD_RSVD_MASK = 8'h3F;

    // A length byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

    function automatic logic cmd_is_legal(input logic [7:0] cmd);
        return (cmd & CMD_RSVD_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/service_loader_if.sv
// Bundle of the service loader's host link and CPU/memory service signals.
//
// Handshake rule for both byte streams: a byte moves on a rising clock edge
// where valid && ready are both high. The sender holds data and valid stable
// until that edge; ready may change freely.
//
// Signals:
//   rx_data/rx_valid/rx_ready  host -> loader command/payload bytes
//   tx_data/tx_valid/tx_ready  loader -> host dump bytes
//   service_mode, cpu_rst      CPU control
//   pm_address/pm_data/pm_we   program memory write port
//   dm_address/dm_data/dm_we   data memory port, dm_rdata is its read data
//
// Modports:
//   master - the loader itself
//   slave  - host link, CPU and memories
interface service_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic       service_mode;
    logic       cpu_rst;

    logic [7:0] pm_address;
    logic [7:0] pm_data;
    logic       pm_we;

    logic [7:0] dm_address;
    logic [7:0] dm_data;
    logic       dm_we;
    logic [7:0] dm_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, dm_rdata,
        output rx_ready, tx_data, tx_valid,
        output service_mode, cpu_rst,
        output pm_address, pm_data, pm_we,
        output dm_address, dm_data, dm_we
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dm_rdata,
        input  rx_ready, tx_data, tx_valid,
        input  service_mode, cpu_rst,
        input  pm_address, pm_data, pm_we,
        input  dm_address, dm_data, dm_we
    );

endinterface

// File: rtl/service_addr_counter.sv
// Wrapping address generator plus remaining-byte counter for bulk transfers.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   load       capture load_addr and the count derived from load_len
//   load_addr  first memory address of the transfer
//   load_len   length header byte (0 means 256)
//   step       one byte transferred: advance address, decrement count
//   addr       current memory address (wraps 0xFF -> 0x00)
//   done       high when the current byte is the last one of the transfer
module service_addr_counter
    import cpu8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_len,
    input  logic       step,
    output logic [7:0] addr,
    output logic       done
);

    logic [8:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= 8'h00;
            count <= 9'd0;
        end else if (load) begin
            addr  <= load_addr;
            count <= len_to_count(load_len);
        end else if (step) begin
            // 8-bit add wraps naturally modulo 256.
            addr  <= addr + 8'd1;
            count <= count - 9'd1;
        end
    end

    // "done" qualifies the step that moves the final byte.
    assign done = (count == 9'd1);

endmodule

// File: rtl/service_loader.sv
// Byte-stream service controller for the cpu8 core.
//
// Parses a command stream from the host link to bulk-load program memory,
// bulk-load data memory, dump data memory back to the host, and release the
// CPU to run. While in service mode the CPU is halted and the loader owns the
// memory service ports.
//
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   bus       host link and service port bundle (master side)
//   err       sticky illegal-command flag, cleared only by rst
//   state     current FSM state, exported for observation
module service_loader
    import cpu8_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    service_loader_if.master         bus,
    output logic                     err,
    output loader_state_t            state
);

    // Decoded command and captured header fields.
    op_t        op_q;
    logic [7:0] addr_q;

    // Registered output copies.
    logic       service_mode_q;
    logic       cpu_rst_q;
    logic [7:0] pm_address_q;
    logic [7:0] pm_data_q;
    logic       pm_we_q;
    logic [7:0] dm_address_q;
    logic [7:0] dm_data_q;
    logic       dm_we_q;

    // Transfer counter interface.
    logic       cnt_load;
    logic       cnt_step;
    logic [7:0] cnt_addr;
    logic       cnt_done;

    logic       rx_fire;
    logic       tx_fire;
    logic       cmd_ok;
    op_t        cmd_op;

    assign bus.rx_ready = (state != ST_READ) && (state != ST_START);
    assign bus.tx_valid = (state == ST_READ);
    assign rx_fire      = bus.rx_valid && bus.rx_ready;
    assign tx_fire      = bus.tx_valid && bus.tx_ready;

    assign cmd_ok = cmd_is_legal(bus.rx_data);
    assign cmd_op = op_t'(bus.rx_data[7:6]);

    // Header length byte arrives in LEN; the address was captured in ADDR.
    assign cnt_load = (state == ST_LEN) && rx_fire;
    assign cnt_step = ((state == ST_WRITE) && rx_fire) ||
                      ((state == ST_READ)  && tx_fire);

    service_addr_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_addr (addr_q),
        .load_len  (bus.rx_data),
        .step      (cnt_step),
        .addr      (cnt_addr),
        .done      (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            op_q           <= OP_LOADP;
            addr_q         <= 8'h00;
            service_mode_q <= 1'b1;
            cpu_rst_q      <= 1'b1;
            pm_address_q   <= 8'h00;
            pm_data_q      <= 8'h00;
            pm_we_q        <= 1'b0;
            dm_address_q   <= 8'h00;
            dm_data_q      <= 8'h00;
            dm_we_q        <= 1'b0;
            err            <= 1'b0;
        end else begin
            // Write strobes are single-cycle unless another byte lands.
            pm_we_q <= 1'b0;
            dm_we_q <= 1'b0;

            unique case (state)
                ST_IDLE, ST_RUNNING: begin
                    if (rx_fire) begin
                        // Any accepted byte halts a running CPU.
                        service_mode_q <= 1'b1;
                        if (!cmd_ok) begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            op_q <= cmd_op;
                            if (cmd_op == OP_RUN) begin
                                cpu_rst_q <= 1'b1;
                                state     <= ST_START;
                            end else begin
                                state <= ST_ADDR;
                            end
                        end
                    end
                end

                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= bus.rx_data;
                        state  <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (rx_fire) begin
                        state <= (op_q == OP_DUMPD) ? ST_READ : ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (rx_fire) begin
                        if (op_q == OP_LOADP) begin
                            pm_address_q <= cnt_addr;
                            pm_data_q    <= bus.rx_data;
                            pm_we_q      <= 1'b1;
                        end else begin
                            dm_address_q <= cnt_addr;
                            dm_data_q    <= bus.rx_data;
                            dm_we_q      <= 1'b1;
                        end
                        // The final write shows up in the first IDLE cycle.
                        if (cnt_done) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_READ: begin
                    if (tx_fire && cnt_done) begin
                        state <= ST_IDLE;
                    end
                end

                ST_START: begin
                    // cpu_rst and service_mode release on the same edge.
                    cpu_rst_q      <= 1'b0;
                    service_mode_q <= 1'b0;
                    state          <= ST_RUNNING;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.service_mode = service_mode_q;
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.pm_address   = pm_address_q;
    assign bus.pm_data      = pm_data_q;
    assign bus.pm_we        = pm_we_q;
    assign bus.dm_data      = dm_data_q;
    assign bus.dm_we        = dm_we_q;

    // During a dump the counter drives the read address directly so that the
    // combinational read data is presented as tx_data in the same cycle.
    assign bus.dm_address = (state == ST_READ) ? cnt_addr : dm_address_q;
    assign bus.tx_data    = (state == ST_READ) ? bus.dm_rdata : 8'h00;

endmodule

// File: doc/service_loader.md
# service_loader

Byte-stream service controller for the 8-bit CPU core. It drives the core's service-mode port and the program/data memory service ports. It parses a simple command stream from a host link (valid/ready bytes) to bulk-load program memory, bulk-load data memory, dump data memory back to the host, and release the CPU to run. It sits between the host link (UART or test harness) and the top-level `cpu8` service inputs.

## Interface
Parameters:
- none; all widths fixed at 8-bit data/address, 256-entry memories

Ports:
- `clk` in 1: single system clock, shared with the CPU core
- `rst` in 1: synchronous, active-high reset
- `rx_data` in 8: incoming host byte
- `rx_valid` in 1: `rx_data` valid
- `rx_ready` out 1: loader accepts a byte when `rx_valid && rx_ready`
- `tx_data` out 8: outgoing dump byte
- `tx_valid` out 1: `tx_data` valid
- `tx_ready` in 1: host accepts a byte when `tx_valid && tx_ready`
- `service_mode` out 1: halts the CPU and hands the memory ports to the loader
- `cpu_rst` out 1: reset to the CPU core's `rst` (ORed externally with system `rst`)
- `pm_address` out 8, `pm_data` out 8, `pm_we` out 1: program memory service port
- `dm_address` out 8, `dm_data` out 8, `dm_we` out 1: data memory service port
- `dm_rdata` in 8: data memory read data; combinational read, valid in the same cycle as `dm_address`
- `err` out 1: sticky error flag, cleared only by `rst`

## Operation
- Command byte encoding: `[7:6]` opcode, `[5:0]` must be 0.
  - 00 LOADP
  - 01 LOADD
  - 10 DUMPD
  - 11 RUN
- LOADP, LOADD and DUMPD are followed by two header bytes: start address `A`, then length `L`. `L`=0 means 256 bytes.
- LOADP and LOADD then take `L` payload bytes. Byte *i* is written to address `(A+i) mod 256`; addresses wrap from 0xFF to 0x00.
- DUMPD emits `L` bytes, reading `(A+i) mod 256` for each.
- RUN: one-cycle `cpu_rst` pulse, then `service_mode` is deasserted.
- FSM states:
  - IDLE: wait for a command byte; `rx_ready`=1
  - ADDR: wait for the address byte; `rx_ready`=1
  - LEN: wait for the length byte; `rx_ready`=1
  - WRITE: receive payload bytes; `rx_ready`=1
  - READ: emit dump bytes; `rx_ready`=0
  - START: `cpu_rst` pulse cycle; `rx_ready`=0
  - RUNNING: CPU executing; `rx_ready`=1
- FSM transitions:
  - IDLE →ADDR on an accepted LOADP/LOADD/DUMPD byte.
  - IDLE →START on an accepted RUN byte.
  - ADDR→LEN→WRITE (LOADP/LOADD) or →READ (DUMPD).
  - WRITE→IDLE after the L-th accepted byte.
  - READ→IDLE after the L-th accepted `tx` handshake.
  - START→RUNNING after 1 cycle.
  - RUNNING: any accepted byte asserts `service_mode` next cycle and is decoded exactly as in IDLE. RUN while RUNNING re-enters START.
- Illegal command (reserved bits nonzero) in IDLE/RUNNING: byte is consumed, `err` is set, next state is IDLE (CPU halted).
- Counter: 9-bit remaining count, loaded with `L==0 ? 256 : L`. Address register is 8-bit and increments modulo 256.
- `service_mode` = 1 in every state except RUNNING.
- `tx_data` = `dm_rdata` combinationally while in READ.

## Timing
- Reset values:
  - `service_mode`=1, `cpu_rst`=1 (CPU held until the first RUN)
  - `pm_we`=`dm_we`=0, `tx_valid`=0, `err`=0
  - `pm_address`=`dm_address`=`pm_data`=`dm_data`=0
  - `rx_ready`=1, state IDLE
- Write path: a payload byte accepted in cycle *n* produces a registered `*_we`=1 with address/data in cycle *n+1*, for exactly one cycle per byte.
- Back-to-back payload bytes give one write per cycle.
- `rx_valid` gaps: `*_we` stays 0 while no byte is accepted.
- `cpu_rst` deasserts in the cycle after START, which is the same cycle `service_mode` falls.
- `tx_valid` is 1 throughout READ. Address advances only on a `tx` handshake. `tx_data` is held stable while `tx_ready`=0.
- WRITE→IDLE: the final write is still issued in the first IDLE cycle. A command byte accepted in that cycle is legal.
- `rst` mid-transfer: everything returns to reset values next edge and the partial load is abandoned; memory contents already written are untouched.

## Structure
- Shared package `cpu8_pkg`:
  - opcode enum (`OP_LOADP`, `OP_LOADD`, `OP_DUMPD`, `OP_RUN`)
  - loader state typedef
  - `CMD_RSVD_MASK` = 8'h3F
- One sub-module: `service_addr_counter`, which holds the 8-bit wrapping address plus the 9-bit remaining count, with `load`, `step` and `done` signals. It is shared by the WRITE and READ states.

## Test plan
- Reset → `service_mode`=1, `cpu_rst`=1, `err`=0; send 0xC0 → one `cpu_rst` pulse, then `service_mode`=0.
- LOADP A=0xFE L=3 bytes 11,22,33 → `pm_we` pulses writing 0xFE=11, 0xFF=22, 0x00=33; returns to IDLE.
- LOADD A=0x10 L=0 with 256 consecutive bytes → 256 `dm_we` cycles, addresses 0x10…0x0F.
- DUMPD A=0x10 L=2 with `tx_ready` toggling → exactly 2 bytes = `mem[0x10]`, `mem[0x11]`; `tx_data` stable while stalled.
- While RUNNING, send 0x41 → `err`=1, `service_mode`=1 next cycle, state IDLE.
- `rst` asserted after 2 of 5 LOADP payload bytes → no further `pm_we`; all outputs at reset values.
